// File: rtl/shift_reg_tap_e.sv
// Addressable shift-register primitive: clock enable, parallel load, cascade tap
// and per-tap fill tracking, with optional registered tap output.
module shift_reg_tap_e #(
  parameter int unsigned      DEPTH   = 32,
  parameter logic [DEPTH-1:0] INIT    = '0,
  parameter bit               REG_OUT = 1'b0,
  parameter int unsigned      ADDR_W  = $clog2(DEPTH)
) (
  input  logic              C,
  input  logic              R,
  input  logic              D,
  input  logic              E,
  input  logic              L,
  input  logic [DEPTH-1:0]  P,
  input  logic [ADDR_W-1:0] A,
  output logic              Q,
  output logic              Q_CASC,
  output logic              VALID
);

  localparam int unsigned FILL_W = $clog2(DEPTH + 1);

  logic [DEPTH-1:0]  sr_q = INIT;
  logic [DEPTH-1:0]  sr_d;
  logic [FILL_W-1:0] fill_q = '0;
  logic [FILL_W-1:0] fill_d;
  logic              tap_c;
  logic              tap_valid_c;

  // Next-state: reset beats load beats shift; fill saturates at DEPTH.
  always_comb begin
    sr_d   = sr_q;
    fill_d = fill_q;
    if (R) begin
      sr_d   = INIT;
      fill_d = '0;
    end else if (L) begin
      sr_d   = P;
      fill_d = FILL_W'(DEPTH);
    end else if (E) begin
      sr_d = {sr_q[DEPTH-2:0], D};
      if (fill_q != FILL_W'(DEPTH)) begin
        fill_d = fill_q + FILL_W'(1);
      end
    end
`ifndef SYNTHESIS
    if ($isunknown({R, L, E})) begin
      sr_d   = 'x;
      fill_d = 'x;
    end
`endif
  end

  always_ff @(posedge C) begin
    sr_q   <= sr_d;
    fill_q <= fill_d;
  end

  // Addresses past the last stage read as empty.
  always_comb begin
    tap_c       = 1'b0;
    tap_valid_c = 1'b0;
    if (32'(A) < DEPTH) begin
      tap_c       = sr_q[A];
      tap_valid_c = 32'(fill_q) > 32'(A);
    end
  end

  assign Q_CASC = sr_q[DEPTH-1];

  if (REG_OUT) begin : g_reg_out
    logic q_q     = 1'b0;
    logic valid_q = 1'b0;
    logic q_d;
    logic valid_d;

    // Captures the pre-edge tap every cycle regardless of E.
    always_comb begin
      q_d     = tap_c;
      valid_d = tap_valid_c;
      if (R) begin
        q_d     = 1'b0;
        valid_d = 1'b0;
      end
`ifndef SYNTHESIS
      if ($isunknown({R, L, E})) begin
        q_d     = 1'bx;
        valid_d = 1'bx;
      end
`endif
    end

    always_ff @(posedge C) begin
      q_q     <= q_d;
      valid_q <= valid_d;
    end

    assign Q     = q_q;
    assign VALID = valid_q;
  end else begin : g_comb_out
    assign Q     = tap_c;
    assign VALID = tap_valid_c;
  end

`ifndef SYNTHESIS
  logic notifier;

  specify
    (posedge C => Q)      = 0;
    (posedge C => Q_CASC) = 0;
    $setuphold(posedge C, D, 0, 0, notifier);
    $setuphold(posedge C, E, 0, 0, notifier);
    $setuphold(posedge C, L, 0, 0, notifier);
    $setuphold(posedge C, R, 0, 0, notifier);
    $width(posedge C, 0);
    $width(negedge C, 0);
  endspecify
`endif

endmodule

// File: tb/tb_shift_reg_tap_e.sv
// Scoreboard bench for shift_reg_tap_e: DEPTH=8 in both output modes plus a
// DEPTH=6 instance for out-of-range tap addresses.
module tb_shift_reg_tap_e;

  logic       C, R, D, E, L;
  logic [7:0] P;
  logic [2:0] A;
  logic       q0, casc0, v0;
  logic       q1, casc1, v1;
  logic       q6, casc6, v6;

  int checks   = 0;
  int failures = 0;

  logic [7:0] m8;
  int         f8;
  logic [5:0] m6;
  int         f6;

  typedef struct packed {
    logic q;
    logic v;
    logic c;
  } exp_t;

  exp_t       comb8_q[$];
  exp_t       comb6_q[$];
  logic [1:0] reg_q[$];

  shift_reg_tap_e #(.DEPTH(8), .INIT(8'hA5), .REG_OUT(1'b0)) u_comb (
    .C(C), .R(R), .D(D), .E(E), .L(L), .P(P), .A(A),
    .Q(q0), .Q_CASC(casc0), .VALID(v0)
  );

  shift_reg_tap_e #(.DEPTH(8), .INIT(8'hA5), .REG_OUT(1'b1)) u_reg (
    .C(C), .R(R), .D(D), .E(E), .L(L), .P(P), .A(A),
    .Q(q1), .Q_CASC(casc1), .VALID(v1)
  );

  shift_reg_tap_e #(.DEPTH(6), .INIT(6'h25), .REG_OUT(1'b0)) u_d6 (
    .C(C), .R(R), .D(D), .E(E), .L(L), .P(P[5:0]), .A(A),
    .Q(q6), .Q_CASC(casc6), .VALID(v6)
  );

  initial begin
    C = 1'b0;
    forever #5 C = ~C;
  end

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // One clock: drive, compare combinational outputs pre-edge, compare registered ones post-edge.
  task automatic cycle(input logic d, input logic e, input logic l, input logic r,
                       input logic [2:0] aa, input logic [7:0] pp);
    exp_t       x;
    logic [1:0] y;
    D = d; E = e; L = l; R = r; A = aa; P = pp;
    #3;
    comb8_q.push_back({m8[aa], f8 > int'(aa), m8[7]});
    if (int'(aa) < 6) comb6_q.push_back({m6[aa], f6 > int'(aa), m6[5]});
    else              comb6_q.push_back({1'b0, 1'b0, m6[5]});
    reg_q.push_back(r ? 2'b00 : {m8[aa], f8 > int'(aa)});

    x = comb8_q.pop_front();
    check("q_comb",     8'(q0),    8'(x.q));
    check("valid_comb", 8'(v0),    8'(x.v));
    check("casc_comb",  8'(casc0), 8'(x.c));
    check("casc_reg",   8'(casc1), 8'(x.c));
    x = comb6_q.pop_front();
    check("q_d6",       8'(q6),    8'(x.q));
    check("valid_d6",   8'(v6),    8'(x.v));
    check("casc_d6",    8'(casc6), 8'(x.c));

    @(posedge C);
    if (r) begin
      m8 = 8'hA5; f8 = 0; m6 = 6'h25; f6 = 0;
    end else if (l) begin
      m8 = pp; f8 = 8; m6 = pp[5:0]; f6 = 6;
    end else if (e) begin
      m8 = {m8[6:0], d}; if (f8 < 8) f8++;
      m6 = {m6[4:0], d}; if (f6 < 6) f6++;
    end
    #1;
    if (reg_q.size() == 0) begin
      checks++; failures++;
      $display("FAIL reg_queue got=empty exp=entry");
    end else begin
      y = reg_q.pop_front();
      check("q_reg",     8'(q1), 8'(y[1]));
      check("valid_reg", 8'(v1), 8'(y[0]));
    end
  endtask

  initial begin
    D = 1'b0; E = 1'b0; L = 1'b0; R = 1'b0; A = 3'd0; P = 8'h00;
    m8 = 8'hA5; f8 = 0; m6 = 6'h25; f6 = 0;
    #1;
    check("pu_q_comb",  8'(q0),    8'd1);
    check("pu_v_comb",  8'(v0),    8'd0);
    check("pu_q_reg",   8'(q1),    8'd0);
    check("pu_v_reg",   8'(v1),    8'd0);
    check("pu_casc",    8'(casc0), 8'd1);
    check("pu_q_d6",    8'(q6),    8'd1);

    // Reset then read every tap of INIT without shifting.
    cycle(0, 0, 0, 1, 3'd0, 8'h00);
    for (int a = 0; a < 8; a++) cycle(0, 0, 0, 0, 3'(a), 8'h00);

    // Impulse travels to tap 3, then tap address moves 3 -> 0.
    cycle(0, 0, 0, 1, 3'd3, 8'h00);
    cycle(1, 1, 0, 0, 3'd3, 8'h00);
    for (int i = 0; i < 5; i++) cycle(0, 1, 0, 0, 3'd3, 8'h00);
    cycle(0, 0, 0, 0, 3'd3, 8'h00);
    cycle(0, 0, 0, 0, 3'd0, 8'h00);
    cycle(0, 0, 0, 0, 3'd0, 8'h00);

    // Same impulse with two stall cycles.
    cycle(0, 0, 0, 1, 3'd3, 8'h00);
    cycle(1, 1, 0, 0, 3'd3, 8'h00);
    cycle(0, 0, 0, 0, 3'd3, 8'h00);
    cycle(0, 0, 0, 0, 3'd3, 8'h00);
    for (int i = 0; i < 6; i++) cycle(0, 1, 0, 0, 3'd3, 8'h00);

    // Load wins over shift; then sweep taps and drain through the cascade.
    cycle(0, 0, 0, 1, 3'd0, 8'h00);
    cycle(1, 1, 1, 0, 3'd0, 8'h3C);
    check("load_casc", 8'(casc0), 8'd0);
    for (int a = 0; a < 8; a++) cycle(1, 0, 0, 0, 3'(a), 8'h00);
    for (int i = 0; i < 9; i++) cycle(0, 1, 0, 0, 3'(i), 8'h00);

    // Reset mid-stream overrides load and shift; refill restarts at 1.
    for (int i = 0; i < 5; i++) cycle(1'($urandom), 1, 0, 0, 3'($urandom), 8'h00);
    cycle(1, 1, 1, 1, 3'd0, 8'hFF);
    cycle(1, 1, 0, 0, 3'd0, 8'h00);
    cycle(0, 0, 0, 0, 3'd1, 8'h00);
    cycle(0, 0, 0, 0, 3'd0, 8'h00);

    // Random traffic including saturation and taps 6/7 on the DEPTH=6 instance.
    for (int i = 0; i < 120; i++) begin
      cycle(1'($urandom), ($urandom_range(0, 3) != 0), ($urandom_range(0, 15) == 0),
            ($urandom_range(0, 31) == 0), 3'($urandom), 8'($urandom));
    end
    for (int i = 0; i < 12; i++) cycle(1'($urandom), 1, 0, 0, 3'($urandom), 8'h00);
    for (int a = 0; a < 8; a++) cycle(0, 0, 0, 0, 3'(a), 8'h00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/shift_reg_tap_e.md
Name: shift_reg_tap_e

Overview:
- Addressable shift-register primitive with clock enable, parallel load, cascade output and fill tracking.
- Sits directly upstream of the enabled flip-flop primitives. Its tap output Q drives the D input of an adjacent enabled D flip-flop to form delay lines and SRL+FF pairs.
- Q_CASC chains instances into deeper delay lines.

Parameters:
- DEPTH, 32, number of shift stages; legal range 2..64.
- INIT, {DEPTH{1'b0}}, DEPTH-bit power-up and reset contents; bit 0 is the newest stage.
- REG_OUT, 0, output mode: 0 = tap output combinational from the shift array; 1 = tap output registered, adding one cycle of latency.
- ADDR_W, $clog2(DEPTH), tap address width; derived, not overridden.

Ports:
- C  input  1  Posedge clock.
- R  input  1  Synchronous, active-high reset.
- D  input  1  Serial data input.
- E  input  1  Active-high shift enable.
- L  input  1  Active-high synchronous parallel load.
- P  input  DEPTH  Parallel load data; bit 0 loads the newest stage.
- A  input  ADDR_W  Tap address; 0 selects the newest stage.
- Q  output  1  Tap output, stage A.
- Q_CASC  output  1  Oldest stage sr[DEPTH-1], always combinational; feeds the D input of the next instance.
- VALID  output  1  Selected tap holds data written since reset (shifted or loaded).

Behaviour:
- Storage: sr[DEPTH-1:0]. fill is a counter 0..DEPTH, saturating at DEPTH.
- All updates occur at posedge C only. Priority order: R > L > E.
- R=1:
  - sr <= INIT, fill <= 0.
  - REG_OUT=1: Q register <= 0 and VALID register <= 0.
  - Overrides L and E in the same cycle.
- L=1, R=0: sr <= P, fill <= DEPTH. E is ignored that cycle.
- E=1, L=0, R=0:
  - sr <= {sr[DEPTH-2:0], D}.
  - fill <= min(fill+1, DEPTH).
- E=0, L=0, R=0: sr and fill hold.
- Tap value:
  - tap = sr[A] when A < DEPTH, else 0.
  - tap_valid = (A < DEPTH) && (fill > A).
- REG_OUT=0:
  - Q = tap and VALID = tap_valid, combinational.
  - Q follows A changes within the same cycle.
  - D sampled with E=1 appears at Q after exactly A+1 enabled edges.
- REG_OUT=1:
  - Q <= tap and VALID <= tap_valid at every posedge C, independent of E.
  - The value captured is the pre-edge tap, i.e. exactly the REG_OUT=0 output delayed one cycle.
  - An A change is visible at Q on the next edge.
- Q_CASC = sr[DEPTH-1], combinational in both modes.
- Power-up, before any edge:
  - sr = INIT, fill = 0, VALID = 0.
  - Q = INIT[A] for REG_OUT=0; Q = 0 for REG_OUT=1.
- Reset values of outputs:
  - Q = INIT[A] (REG_OUT=0) or 0 (REG_OUT=1), after the reset edge.
  - Q_CASC = INIT[DEPTH-1].
  - VALID = 0.
- Boundary conditions:
  - fill saturates; further shifts keep VALID=1 for all legal A.
  - A >= DEPTH (non-power-of-2 DEPTH): Q=0, VALID=0.
  - L and E high together: load wins and D is discarded.
  - Reset mid-stream: prior contents are lost; INIT appears and refill starts from 0 on the next enabled edge.
  - X/Z on E, L or R at an edge: sr, fill and the output registers go to X (simulation model only).
- Timing, under `ifndef SYNTHESIS:
  - specify block with posedge C => Q and posedge C => Q_CASC paths, zero delay.
  - $setuphold on D, E, L and R relative to posedge C, with a notifier.
  - $width checks on C high and low.

Test Plan:
- DEPTH=8, REG_OUT=0, INIT=8'hA5, R pulse, then A=0..7 with no edges -> Q = 1,0,1,0,0,1,0,1; Q_CASC=1; VALID=0 for every A.
- DEPTH=8, A=3, E=1, serial D = 1,0,0,0,0,0 -> Q=1 immediately after the 4th enabled edge and 0 after the 5th; VALID rises after the 4th edge.
- Same stimulus as the previous scenario but E=0 on cycles 2 and 3 -> Q=1 appears two cycles later than without stalls; sr holds during the stalls; fill reaches 4 on the 4th enabled edge.
- DEPTH=8, L=1 with E=1 and P=8'h3C -> sr=8'h3C and VALID=1 for all A; D ignored; subsequent E shifts produce Q_CASC = 0,0,1,1,1,1,0,0.
- REG_OUT=1, repeat the second scenario -> Q and VALID lag the REG_OUT=0 results by exactly one cycle; an A change from 3 to 0 is reflected at the next edge.
- Mid-stream: after 5 enabled shifts, assert R together with L=1 and E=1 -> sr=INIT, VALID=0, Q=0 (REG_OUT=1); the next enabled edge sets fill=1.
